// File: rtl/opb_regbank_pkg.sv
// Shared constants, FSM encoding, request payload and address helper for the
// OPB control-register bank.
package opb_regbank_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NUM_LANES  = WORD_W / BYTE_W;
    // OPB numbers bits MSB-first, so bit 31 is the word's LSB
    localparam int unsigned COMMIT_BIT = 31;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    typedef struct packed {
        logic                 rnw;
        logic [NUM_LANES-1:0] be;
        logic [WORD_W-1:0]    addr;
        logic [WORD_W-1:0]    data;
    } opb_req_t;

    function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                      input logic [WORD_W-1:0] base);
        logic [WORD_W-1:0] diff;
        diff = addr - base;
        return {2'b00, diff[WORD_W-1:2]};
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB master/slave signal bundle for the control-register bank.
interface opb_register_bank_ppc2simulink_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic [0:AWIDTH-1]   OPB_ABus;
    logic [0:DWIDTH/8-1] OPB_BE;
    logic [0:DWIDTH-1]   OPB_DBus;
    logic                OPB_RNW;
    logic                OPB_select;
    logic                OPB_seqAddr;
    logic [0:DWIDTH-1]   Sl_DBus;
    logic                Sl_xferAck;
    logic                Sl_errAck;
    logic                Sl_retry;
    logic                Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_regbank_byte_reg.sv
// One 32-bit control register: byte-enable shadow plus optional committed
// output stage.
module opb_regbank_byte_reg
    import opb_regbank_pkg::*;
#(
    parameter bit                DOUBLE_BUFFER = 1'b1,
    parameter logic [WORD_W-1:0] RESET_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [WORD_W-1:0]    wdata_i,
    input  logic                 commit_i,
    output logic [WORD_W-1:0]    shadow_o,
    output logic [WORD_W-1:0]    data_o
);

    logic [WORD_W-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            for (int j = 0; j < int'(NUM_LANES); j++) begin
                if (be_i[j]) begin
                    shadow_d[j*BYTE_W +: BYTE_W] = wdata_i[j*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RESET_VALUE;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

    generate
        if (DOUBLE_BUFFER) begin : g_dbuf
            logic [WORD_W-1:0] data_q;

            // Commit samples the pre-write shadow so a same-edge write lands next time
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= RESET_VALUE;
                end else if (commit_i) begin
                    data_q <= shadow_q;
                end
            end

            assign data_o = data_q;
        end else begin : g_direct
            logic unused_commit;
            assign unused_commit = commit_i;
            assign data_o        = shadow_q;
        end
    endgenerate

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software-written control registers to the
// fabric, with byte-enable writes, read-back and atomic commit.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0]  C_BASEADDR      = 32'h0108_0000,
    parameter logic [31:0]  C_HIGHADDR      = 32'h0108_00FF,
    parameter int unsigned  C_OPB_AWIDTH    = 32,
    parameter int unsigned  C_OPB_DWIDTH    = 32,
    parameter int unsigned  C_NUM_REGS      = 4,
    parameter int unsigned  C_DOUBLE_BUFFER = 1,
    parameter logic [31:0]  C_RESET_VALUE   = 32'h0000_0000
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    input  logic                         user_commit_req,
    output logic [WORD_W*C_NUM_REGS-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]        user_wr_strobe,
    output logic                         user_commit
);

    localparam int unsigned     AW   = C_OPB_AWIDTH;
    localparam int unsigned     DW   = C_OPB_DWIDTH;
    localparam logic [AW-1:0]   BASE = AW'(C_BASEADDR);
    localparam logic [AW-1:0]   HIGH = AW'(C_HIGHADDR);

    opb_req_t            req;
    logic                hit;
    logic [WORD_W-1:0]   offset;
    logic [WORD_W-1:0]   rd_word;
    logic [WORD_W-1:0]   shadow [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] wr_sel;
    logic                commit_now;

    logic [0:0]            state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [C_NUM_REGS-1:0] strobe_q, strobe_d;
    logic                  commit_q, commit_d;
    logic                  dirty_q, dirty_d;

    assign req = '{rnw:  opb.OPB_RNW,
                   be:   NUM_LANES'(opb.OPB_BE),
                   addr: WORD_W'(opb.OPB_ABus),
                   data: WORD_W'(opb.OPB_DBus)};

    assign hit    = (opb.OPB_ABus >= BASE) && (opb.OPB_ABus <= HIGH);
    assign offset = word_offset(req.addr, WORD_W'(BASE));

    // Read-back mux: shadows, then the commit/dirty word, anything else reads 0
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(C_NUM_REGS); i++) begin
            if (offset == WORD_W'(i)) begin
                rd_word = shadow[i];
            end
        end
        if (offset == WORD_W'(C_NUM_REGS)) begin
            rd_word = {{(WORD_W-1){1'b0}}, dirty_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        rdata_d    = '0;
        wr_sel     = '0;
        commit_now = user_commit_req;
        dirty_d    = dirty_q;

        case (state_q)
            ST_IDLE: begin
                if (opb.OPB_select && hit) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (req.rnw) begin
                        rdata_d = DW'(rd_word);
                    end else begin
                        for (int i = 0; i < int'(C_NUM_REGS); i++) begin
                            wr_sel[i] = (offset == WORD_W'(i));
                        end
                        if ((offset == WORD_W'(C_NUM_REGS)) && opb.OPB_DBus[COMMIT_BIT]) begin
                            commit_now = 1'b1;
                        end
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A shadow write on a commit edge leaves fresh data pending
        if (|wr_sel) begin
            dirty_d = 1'b1;
        end else if (commit_now) begin
            dirty_d = 1'b0;
        end

        strobe_d = wr_sel;
        commit_d = commit_now;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            strobe_q <= '0;
            commit_q <= 1'b0;
            dirty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
            commit_q <= commit_d;
            dirty_q  <= dirty_d;
        end
    end

    generate
        for (genvar i = 0; i < int'(C_NUM_REGS); i++) begin : g_reg
            opb_regbank_byte_reg #(
                .DOUBLE_BUFFER (C_DOUBLE_BUFFER != 0),
                .RESET_VALUE   (C_RESET_VALUE)
            ) u_reg (
                .clk      (OPB_Clk),
                .rst_n    (OPB_Rst_n),
                .wr_en_i  (wr_sel[i]),
                .be_i     (req.be),
                .wdata_i  (req.data),
                .commit_i (commit_now),
                .shadow_o (shadow[i]),
                .data_o   (user_data_out[i*WORD_W +: WORD_W])
            );
        end
    endgenerate

    assign opb.Sl_DBus    = rdata_q;
    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign user_wr_strobe = strobe_q;
    assign user_commit    = commit_q;

    logic unused_ok;
    assign unused_ok = ^{1'b0, opb.OPB_seqAddr};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Scoreboard bench: bus tasks predict responses from a register-array model,
// a negedge monitor compares them whenever the slave acknowledges.
module tb_opb_register_bank_ppc2simulink;

    localparam int          NREG = 4;
    localparam logic [31:0] BASE = 32'h0108_0000;
    localparam logic [31:0] HIGH = 32'h0108_00FF;

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  strobe;
        logic        commit;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic user_commit_req;
    logic [32*NREG-1:0] user_data_out;
    logic [NREG-1:0]    user_wr_strobe;
    logic               user_commit;

    opb_register_bank_ppc2simulink_if bus ();

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR      (BASE),
        .C_HIGHADDR      (HIGH),
        .C_OPB_AWIDTH    (32),
        .C_OPB_DWIDTH    (32),
        .C_NUM_REGS      (NREG),
        .C_DOUBLE_BUFFER (1),
        .C_RESET_VALUE   (32'h0)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .opb             (bus),
        .user_commit_req (user_commit_req),
        .user_data_out   (user_data_out),
        .user_wr_strobe  (user_wr_strobe),
        .user_commit     (user_commit)
    );

    always #5 clk = ~clk;

    logic [31:0] shadow_m [NREG];
    logic [31:0] out_m    [NREG];
    bit          dirty_m;
    exp_t        expq [$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endfunction

    function automatic logic [127:0] model_out();
        return {out_m[3], out_m[2], out_m[1], out_m[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            shadow_m[i] = '0;
            out_m[i]    = '0;
        end
        dirty_m = 1'b0;
    endfunction

    // Monitor: every acked cycle must match the oldest prediction
    initial begin
        exp_t        e;
        logic [31:0] dbus_v;
        forever begin
            @(negedge clk);
            dbus_v = bus.Sl_DBus;
            if (rst_n && bus.Sl_xferAck) begin
                if (expq.size() == 0) begin
                    chk("unexpected_ack", 128'(bus.Sl_xferAck), 128'(0));
                end else begin
                    e = expq.pop_front();
                    chk("read_data", 128'(dbus_v), 128'(e.rd));
                    chk("wr_strobe", 128'(user_wr_strobe), 128'(e.strobe));
                    chk("commit_pulse", 128'(user_commit), 128'(e.commit));
                end
            end else if (rst_n) begin
                chk("idle_dbus", 128'(dbus_v), 128'(0));
                chk("idle_strobe", 128'(user_wr_strobe), 128'(0));
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                        input logic [31:0] data, input logic hw);
        bit          hit, wrote, cm;
        int          off;
        logic [31:0] rd;
        logic [31:0] pre [NREG];
        @(negedge clk);
        bus.OPB_ABus    = addr;
        bus.OPB_RNW     = rnw;
        bus.OPB_BE      = be;
        bus.OPB_DBus    = data;
        bus.OPB_select  = 1'b1;
        user_commit_req = hw;
        @(posedge clk);
        hit   = (addr >= BASE) && (addr <= HIGH);
        off   = int'((addr - BASE) >> 2);
        rd    = '0;
        wrote = 1'b0;
        cm    = hw;
        if (hit) begin
            if (rnw) begin
                if (off < NREG)       rd = shadow_m[off];
                else if (off == NREG) rd = {31'b0, dirty_m};
            end else if (off < NREG) begin
                wrote = 1'b1;
            end else if (off == NREG && data[0]) begin
                cm = 1'b1;
            end
        end
        pre = shadow_m;
        if (wrote) begin
            for (int j = 0; j < 4; j++)
                if (be[j]) shadow_m[off][8*j +: 8] = data[8*j +: 8];
            dirty_m = 1'b1;
        end
        if (cm) begin
            out_m = pre;
            if (!wrote) dirty_m = 1'b0;
        end
        if (hit) expq.push_back('{rd: rd, strobe: wrote ? 4'(1 << off) : 4'b0, commit: cm});
        @(negedge clk);
        bus.OPB_select  = 1'b0;
        user_commit_req = 1'b0;
        if (!hit) begin
            chk("no_ack_out_of_range", 128'(bus.Sl_xferAck), 128'(0));
            chk("commit_no_xfer", 128'(user_commit), 128'(cm));
        end
        @(negedge clk);
        chk("user_data_out", user_data_out, model_out());
    endtask

    task automatic hw_commit();
        @(negedge clk);
        user_commit_req = 1'b1;
        @(posedge clk);
        out_m   = shadow_m;
        dirty_m = 1'b0;
        @(negedge clk);
        user_commit_req = 1'b0;
        chk("hw_commit_pulse", 128'(user_commit), 128'(1));
        chk("hw_commit_out", user_data_out, model_out());
        @(negedge clk);
        chk("hw_commit_single", 128'(user_commit), 128'(0));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        rst_n           = 1'b0;
        user_commit_req = 1'b0;
        bus.OPB_ABus    = '0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ack", 128'(bus.Sl_xferAck), 128'(0));
        chk("reset_out", user_data_out, model_out());
        chk("reset_commit", 128'(user_commit), 128'(0));

        xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h04, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        xfer(BASE + 32'h04, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h00, 1'b0, 4'hF, 32'h1122_3344, 1'b0);
        xfer(BASE + 32'h00, 1'b0, 4'b0101, 32'hAABB_CCDD, 1'b0);
        xfer(BASE + 32'h00, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h0C, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0000_0001, 1'b0);
        xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h08, 1'b0, 4'hF, 32'h0000_0003, 1'b0);
        xfer(BASE + 32'h08, 1'b0, 4'hF, 32'h0000_0005, 1'b1);
        xfer(BASE + 32'h08, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0000_0001, 1'b1);
        xfer(32'h0108_0100, 1'b0, 4'hF, 32'h1234_5678, 1'b0);
        xfer(32'h0108_0100, 1'b1, 4'hF, 32'h0, 1'b1);
        xfer(32'h0108_00F0, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(32'h0108_00F0, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0);
        hw_commit();

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = 32'h0108_0100 + 32'(4 * $urandom_range(0, 3));
            else if (r == 1) a = 32'h0108_00F0;
            else if (r == 2) a = 32'h0107_FFFC;
            else             a = BASE + 32'(4 * $urandom_range(0, NREG + 1));
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom),
                 $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) hw_commit();
        end

        // Reset landing in the ACK cycle must kill the acknowledge at once
        @(negedge clk);
        bus.OPB_ABus   = BASE + 32'h04;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_BE     = 4'hF;
        bus.OPB_DBus   = 32'h1234_5678;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_abort_ack", 128'(bus.Sl_xferAck), 128'(0));
        chk("reset_abort_strobe", 128'(user_wr_strobe), 128'(0));
        model_reset();
        @(negedge clk);
        bus.OPB_select = 1'b0;
        chk("reset_abort_out", user_data_out, model_out());
        @(negedge clk);
        rst_n = 1'b1;
        xfer(BASE + 32'h04, 1'b1, 4'hF, 32'h0, 1'b0);
        xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", 128'(expq.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
